// File: rtl/apb_master.sv
// APB master: turns single user commands into APB3/APB4 transfers.
// Aborts a transfer that waits TIMEOUT ACCESS cycles without pready.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strb,
    input  logic [2:0]  cmd_prot,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [8:0] TMO = {1'b0, TIMEOUT[7:0]};

    state_t     state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_inc;
    logic       expire;

    // Ready for a new command only when no transfer is in flight.
    assign cmd_ready = (state == IDLE);

    // Saturating wait counter increment and timeout detection.
    assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    assign expire   = ({1'b0, wait_cnt} + 9'd1) >= TMO;

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= 32'd0;
            pwdata      <= 32'd0;
            pstrb       <= 4'd0;
            pprot       <= 3'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr   <= cmd_addr;
                        pwrite  <= cmd_write;
                        pwdata  <= cmd_wdata;
                        pstrb   <= cmd_write ? cmd_strb : 4'b0000;
                        pprot   <= cmd_prot;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= 8'd0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? 32'd0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (expire) begin
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= 32'd0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master.
// Scripted responder plus timeline model of each transfer.
module tb_apb_master;

    localparam int TO = 16;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_master #(.TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Per-command responder plan supplied with each command
    int          p_wait;
    logic [31:0] p_rdata;
    logic        p_err;

    // Model: cycle index k within transfer (-1 = not busy)
    int          m_k;
    int          m_len;
    int          m_wait;
    logic        m_to;
    logic [31:0] m_prdata;
    logic        m_slverr;
    logic        m_rv;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_write, e_err, e_to;
    logic [3:0]  e_strb;
    logic [2:0]  e_prot;

    always @(posedge pclk or negedge preset) begin
        if (!preset) begin
            m_k <= -1; m_len <= 1; m_wait <= 0; m_to <= 1'b0;
            m_prdata <= 32'd0; m_slverr <= 1'b0; m_rv <= 1'b0;
            e_addr <= 32'd0; e_wdata <= 32'd0; e_rdata <= 32'd0;
            e_write <= 1'b0; e_err <= 1'b0; e_to <= 1'b0;
            e_strb <= 4'd0; e_prot <= 3'd0;
        end else begin
            m_rv <= 1'b0;
            if (m_k < 0) begin
                if (cmd_valid) begin
                    m_k      <= 0;
                    e_addr   <= cmd_addr;
                    e_write  <= cmd_write;
                    e_wdata  <= cmd_wdata;
                    e_strb   <= cmd_write ? cmd_strb : 4'b0000;
                    e_prot   <= cmd_prot;
                    m_wait   <= p_wait;
                    m_prdata <= p_rdata;
                    m_slverr <= p_err;
                    m_to     <= (p_wait + 1 > TO);
                    m_len    <= (p_wait + 1 > TO) ? TO : p_wait + 1;
                end
            end else if (m_k == m_len) begin
                m_rv    <= 1'b1;
                m_k     <= -1;
                e_rdata <= (m_to || e_write) ? 32'd0 : m_prdata;
                e_err   <= m_to | m_slverr;
                e_to    <= m_to;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Responder: ready after m_wait wait states, junk otherwise
    always_comb begin
        pready  = (m_k >= 1) && (m_k == m_wait + 1);
        prdata  = pready ? m_prdata : ~m_prdata;
        pslverr = pready ? m_slverr : 1'b1;
    end

    // Observed statistics
    int          cyc = 0;
    int          n_psel = 0, n_pen = 0, n_rsp = 0;
    int          last_setup = 0, setup_gap = 0;
    logic [31:0] l_rdata = 0;
    logic        l_err = 0, l_to = 0;
    logic [3:0]  l_pstrb = 0;

    always @(negedge pclk) begin
        if (preset) begin
            cyc++;
            chk("psel", 32'(psel), 32'(m_k >= 0));
            chk("penable", 32'(penable), 32'(m_k >= 1));
            chk("cmd_ready", 32'(cmd_ready), 32'(m_k < 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            if (m_rv) begin
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
            end
            chk("paddr", paddr, e_addr);
            chk("pwrite", 32'(pwrite), 32'(e_write));
            chk("pwdata", pwdata, e_wdata);
            chk("pstrb", 32'(pstrb), 32'(e_strb));
            chk("pprot", 32'(pprot), 32'(e_prot));
            if (psel) n_psel++;
            if (psel && penable) begin
                n_pen++;
                l_pstrb = pstrb;
            end
            if (psel && !penable) begin
                setup_gap = cyc - last_setup;
                last_setup = cyc;
            end
            if (rsp_valid) begin
                n_rsp++;
                l_rdata = rsp_rdata;
                l_err = rsp_err;
                l_to = rsp_timeout;
            end
        end
    end

    task automatic send(input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] pr, input int wt,
                        input logic [31:0] rd, input bit er,
                        input bit keep);
        bit idle;
        bit ok;
        @(posedge pclk);
        #1;
        cmd_write = w; cmd_addr = a; cmd_wdata = d;
        cmd_strb = s; cmd_prot = pr;
        p_wait = wt; p_rdata = rd; p_err = er;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge pclk);
            idle = (m_k < 0);
            @(posedge pclk);
            if (idle) ok = 1'b1;
        end
        #1;
        if (!keep) cmd_valid = 1'b0;
        chk("accept_bound", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge pclk);
            if (m_rv) ok = 1'b1;
        end
        chk("done_bound", 32'(ok), 32'd1);
    endtask

    int b_psel, b_pen, b_rsp;

    task automatic snap();
        b_psel = n_psel;
        b_pen = n_pen;
        b_rsp = n_rsp;
    endtask

    initial begin
        preset = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_wdata = 32'd0; cmd_strb = 4'd0; cmd_prot = 3'd0;
        p_wait = 0; p_rdata = 32'd0; p_err = 1'b0;
        #12;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pstrb", 32'(pstrb), 32'd0);
        chk("rst_pprot", 32'(pprot), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write 0x10 presented before reset release
        cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
        cmd_strb = 4'hF; cmd_prot = 3'd2;
        p_wait = 0; p_rdata = 32'h55AA55AA; p_err = 1'b0;
        cmd_valid = 1'b1;
        snap();
        #10 preset = 1'b1;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        chk("first_accept_psel", 32'(psel), 32'd1);
        wait_done();
        #1;
        chk("wr_psel_cycles", 32'(n_psel - b_psel), 32'd2);
        chk("wr_pen_cycles", 32'(n_pen - b_pen), 32'd1);
        chk("wr_rsp_count", 32'(n_rsp - b_rsp), 32'd1);
        chk("wr_rsp_err", 32'(l_err), 32'd0);
        chk("wr_rsp_rdata", l_rdata, 32'd0);

        // Read 0x20 with 3 wait states, strobes must be forced to 0
        snap();
        send(1'b0, 32'h20, 32'h0, 4'hF, 3'd5, 3, 32'h12345678, 1'b0, 1'b0);
        wait_done();
        #1;
        chk("rd_pen_cycles", 32'(n_pen - b_pen), 32'd4);
        chk("rd_rsp_rdata", l_rdata, 32'h12345678);
        chk("rd_pstrb", 32'(l_pstrb), 32'd0);

        // Read with slave error
        send(1'b0, 32'h24, 32'h0, 4'h0, 3'd1, 1, 32'hA5A5A5A5, 1'b1, 1'b0);
        wait_done();
        #1;
        chk("err_rsp_err", 32'(l_err), 32'd1);
        chk("err_rsp_timeout", 32'(l_to), 32'd0);

        // Responder never ready: abort after TIMEOUT ACCESS cycles
        snap();
        send(1'b0, 32'h30, 32'h0, 4'h0, 3'd0, 255, 32'h77777777, 1'b0, 1'b0);
        wait_done();
        #1;
        chk("to_pen_cycles", 32'(n_pen - b_pen), 32'd16);
        chk("to_rsp_err", 32'(l_err), 32'd1);
        chk("to_rsp_timeout", 32'(l_to), 32'd1);
        chk("to_rsp_rdata", l_rdata, 32'd0);

        // Ready on the very edge the count reaches TIMEOUT
        snap();
        send(1'b0, 32'h34, 32'h0, 4'h0, 3'd3, 15, 32'hCAFEF00D, 1'b0, 1'b0);
        wait_done();
        #1;
        chk("edge_pen_cycles", 32'(n_pen - b_pen), 32'd16);
        chk("edge_rsp_timeout", 32'(l_to), 32'd0);
        chk("edge_rsp_rdata", l_rdata, 32'hCAFEF00D);

        // Reset during ACCESS
        send(1'b1, 32'h40, 32'h01020304, 4'h5, 3'd7, 10, 32'h0, 1'b0, 1'b0);
        repeat (3) @(negedge pclk);
        snap();
        #2 preset = 1'b0;
        #1;
        chk("mid_rst_psel", 32'(psel), 32'd0);
        chk("mid_rst_penable", 32'(penable), 32'd0);
        @(negedge pclk);
        #2 preset = 1'b1;
        repeat (4) @(negedge pclk);
        chk("mid_rst_no_rsp", 32'(n_rsp - b_rsp), 32'd0);
        snap();
        send(1'b1, 32'h44, 32'h0BADCAFE, 4'h3, 3'd4, 2, 32'h0, 1'b0, 1'b0);
        wait_done();
        #1;
        chk("post_rst_rsp_count", 32'(n_rsp - b_rsp), 32'd1);
        chk("post_rst_rsp_err", 32'(l_err), 32'd0);

        // cmd_valid held high across two writes
        snap();
        send(1'b1, 32'h50, 32'h11111111, 4'hC, 3'd1, 0, 32'h0, 1'b0, 1'b1);
        send(1'b1, 32'h54, 32'h22222222, 4'h3, 3'd6, 0, 32'h0, 1'b0, 1'b0);
        wait_done();
        #1;
        chk("b2b_setup_gap", 32'(setup_gap), 32'd3);
        chk("b2b_rsp_count", 32'(n_rsp - b_rsp), 32'd2);

        repeat (3) @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
